// File: rtl/dec_lut_bsearch_decoder.sv
// Binary-search inverse of a strictly increasing codeword LUT (exact or floor match) over a
// synchronous read port; RD_LAT+2 cycles per probe, start ignored while busy; ITER_COUNT_EN adds iter_cnt.
module dec_lut_bsearch_decoder #(
    parameter int N_BITS = 20,
    parameter int W_BITS = 34,
    parameter int RD_LAT = 1,
    parameter int MODE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [W_BITS-1:0] W,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [N_BITS-1:0] N,
    output logic              lut_rd_en,
    output logic [N_BITS-1:0] lut_addr,
    input  logic [W_BITS-1:0] lut_rdata
`ifdef ITER_COUNT_EN
    ,
    output logic [$clog2(N_BITS+2)-1:0] iter_cnt
`endif
);

    localparam int AW = N_BITS + 1;
    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, CMP, DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     lo_q, lo_d, hi_q, hi_d;
    logic [AW-1:0]     mid, lo_nx, hi_nx;
    logic [W_BITS-1:0] w_q, w_d, rdata_q, rdata_d;
    logic [N_BITS-1:0] best_q, best_d, n_q, n_d;
    logic              best_vld_q, best_vld_d, found_q, found_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              term;

    // Bounds are one bit wider than the index so lo can pass the top entry.
    assign mid = lo_q + ((hi_q - lo_q) >> 1);

    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        w_d        = w_q;
        rdata_d    = rdata_q;
        best_d     = best_q;
        best_vld_d = best_vld_q;
        found_d    = found_q;
        n_d        = n_q;
        wait_d     = wait_q;
        lo_nx      = lo_q;
        hi_nx      = hi_q;
        term       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d        = W;
                    lo_d       = '0;
                    hi_d       = {1'b0, {N_BITS{1'b1}}};
                    best_d     = '0;
                    best_vld_d = 1'b0;
                    found_d    = 1'b0;
                    n_d        = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q == WW'(RD_LAT - 1)) begin
                    rdata_d = lut_rdata;
                    state_d = CMP;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            CMP: begin
                if (rdata_q == w_q) begin
                    found_d = 1'b1;
                    n_d     = mid[N_BITS-1:0];
                    state_d = DONE;
                end else begin
                    if (rdata_q < w_q) begin
                        if (MODE == 1) begin
                            best_d     = mid[N_BITS-1:0];
                            best_vld_d = 1'b1;
                        end
                        lo_nx = mid + AW'(1);
                    end else if (mid == '0) begin
                        term = 1'b1;
                    end else begin
                        hi_nx = mid - AW'(1);
                    end
                    lo_d = lo_nx;
                    hi_d = hi_nx;
                    if (term || (lo_nx > hi_nx)) begin
                        state_d = DONE;
                        if ((MODE == 1) && best_vld_d) begin
                            found_d = 1'b1;
                            n_d     = best_d;
                        end else begin
                            found_d = 1'b0;
                            n_d     = '0;
                        end
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lo_q       <= '0;
            hi_q       <= '0;
            w_q        <= '0;
            rdata_q    <= '0;
            best_q     <= '0;
            best_vld_q <= 1'b0;
            found_q    <= 1'b0;
            n_q        <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            w_q        <= w_d;
            rdata_q    <= rdata_d;
            best_q     <= best_d;
            best_vld_q <= best_vld_d;
            found_q    <= found_d;
            n_q        <= n_d;
            wait_q     <= wait_d;
        end
    end

    assign busy      = (state_q == REQ) || (state_q == WAIT) || (state_q == CMP);
    assign done      = (state_q == DONE);
    assign found     = found_q;
    assign N         = n_q;
    assign lut_rd_en = (state_q == REQ);
    assign lut_addr  = mid[N_BITS-1:0];

`ifdef ITER_COUNT_EN
    localparam int IW = $clog2(N_BITS + 2);
    logic [IW-1:0] iter_q, iter_d;

    always_comb begin
        iter_d = iter_q;
        if ((state_q == IDLE) && start) begin
            iter_d = '0;
        end else if (state_q == REQ) begin
            iter_d = iter_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_q <= '0;
        end else begin
            iter_q <= iter_d;
        end
    end

    assign iter_cnt = iter_q;
`endif

endmodule

// File: tb/tb_dec_lut_bsearch_decoder.sv
// Bench: two decoders (exact/RD_LAT=1, floor/RD_LAT=3) on LUT[i]=3*i+1, checked against an arithmetic model.
module tb_dec_lut_bsearch_decoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [33:0] W;
    logic [1:0]  busy, done, found, rd_en;
    logic [19:0] n     [2];
    logic [19:0] addr  [2];
    logic [33:0] rdata [2];
`ifdef ITER_COUNT_EN
    logic [4:0]  itc   [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dec_lut_bsearch_decoder #(.N_BITS(20), .W_BITS(34), .RD_LAT(1), .MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .W(W),
        .busy(busy[0]), .done(done[0]), .found(found[0]), .N(n[0]),
        .lut_rd_en(rd_en[0]), .lut_addr(addr[0]), .lut_rdata(rdata[0])
`ifdef ITER_COUNT_EN
        , .iter_cnt(itc[0])
`endif
    );

    dec_lut_bsearch_decoder #(.N_BITS(20), .W_BITS(34), .RD_LAT(3), .MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .W(W),
        .busy(busy[1]), .done(done[1]), .found(found[1]), .N(n[1]),
        .lut_rd_en(rd_en[1]), .lut_addr(addr[1]), .lut_rdata(rdata[1])
`ifdef ITER_COUNT_EN
        , .iter_cnt(itc[1])
`endif
    );

    // LUT read ports: data shows up exactly RD_LAT cycles after the strobe, garbage otherwise.
    for (genvar g = 0; g < 2; g++) begin : g_lut
        localparam int L = (g == 0) ? 1 : 3;
        logic [19:0] pa [L];
        logic        pv [L];
        always @(posedge clk) begin
            pa[0] <= addr[g];
            pv[0] <= rd_en[g];
            for (int k = 1; k < L; k++) begin
                pa[k] <= pa[k-1];
                pv[k] <= pv[k-1];
            end
        end
        assign rdata[g] = pv[L-1] ? (34'(pa[L-1]) * 34'd3 + 34'd1) : {34{1'b1}};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: exact hit iff w = 3i+1 with i in range; floor = largest i with 3i+1 <= w.
    function automatic void ref_model(input int mode, input longint w, output logic f, output logic [19:0] idx_o);
        longint idx;
        f     = 1'b0;
        idx_o = '0;
        if (w >= 1) begin
            idx = (w - 1) / 3;
            if (mode == 0) begin
                if (((w - 1) % 3 == 0) && (idx < 1048576)) begin
                    f     = 1'b1;
                    idx_o = 20'(idx);
                end
            end else begin
                if (idx > 1048575) idx = 1048575;
                f     = 1'b1;
                idx_o = 20'(idx);
            end
        end
    endfunction

    task automatic run(input logic [33:0] w, input bit dbl, input logic [33:0] w2);
        int          ndone [2];
        int          nrd   [2];
        logic        rf    [2];
        logic [19:0] rn    [2];
        int          last;
        logic        ef;
        logic [19:0] en;
        for (int i = 0; i < 2; i++) begin
            ndone[i] = 0; nrd[i] = 0; rf[i] = 1'bx; rn[i] = 'x;
        end
        @(negedge clk);
        W     = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("busy_after_start", 64'(busy[i]), 64'd1);
            chk("found_cleared_on_start", 64'(found[i]), 64'd0);
        end
        last = -1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (rd_en[i]) nrd[i]++;
                if (done[i]) begin
                    ndone[i]++;
                    rf[i] = found[i];
                    rn[i] = n[i];
                    chk("busy_low_in_done", 64'(busy[i]), 64'd0);
                end
            end
            if (dbl && c == 2) begin
                W     = w2;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (ndone[0] > 0 && ndone[1] > 0 && last < 0) last = c;
            if (last >= 0 && c >= last + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ref_model(i, longint'(w), ef, en);
            chk("done_pulses", 64'(ndone[i]), 64'd1);
            chk("found", 64'(rf[i]), 64'(ef));
            chk("index", 64'(rn[i]), 64'(en));
            chk("found_held", 64'(found[i]), 64'(ef));
            chk("probe_bound", 64'((nrd[i] >= 1) && (nrd[i] <= 21)), 64'd1);
`ifdef ITER_COUNT_EN
            chk("iter_cnt_range", 64'((itc[i] >= 5'd1) && (itc[i] <= 5'd21)), 64'd1);
            chk("iter_cnt_vs_strobes", 64'(itc[i]), 64'(nrd[i]));
`endif
        end
    endtask

    task automatic chk_reset_state();
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", 64'(busy[i]), 64'd0);
            chk("rst_done", 64'(done[i]), 64'd0);
            chk("rst_found", 64'(found[i]), 64'd0);
            chk("rst_N", 64'(n[i]), 64'd0);
            chk("rst_rd_en", 64'(rd_en[i]), 64'd0);
            chk("rst_addr", 64'(addr[i]), 64'd0);
`ifdef ITER_COUNT_EN
            chk("rst_iter_cnt", 64'(itc[i]), 64'd0);
`endif
        end
    endtask

    initial begin
        logic [33:0] w, w2;
        rst_n = 1'b0;
        start = 1'b0;
        W     = '0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;

        run(34'd3145726, 1'b0, '0);
        run(34'd1,       1'b0, '0);
        run(34'd2,       1'b0, '0);
        run(34'd0,       1'b0, '0);
        run(34'd4000000, 1'b0, '0);
        run(34'd3145727, 1'b0, '0);
        run(34'd700,     1'b1, 34'd31);
        run(34'd31,      1'b1, 34'd3145726);

        // Reset dropped while both searches sit in WAIT.
        @(negedge clk);
        W     = 34'd3000001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("rst_hold_done", 64'(done[i]), 64'd0);
                chk("rst_hold_rd_en", 64'(rd_en[i]), 64'd0);
            end
        end
        rst_n = 1'b1;
        run(34'd31, 1'b0, '0);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 1) == 1) w = 34'(longint'($urandom_range(0, 1048575)) * 3 + 1);
            else                           w = 34'($urandom_range(0, 3300000));
            w2 = 34'($urandom_range(0, 3300000));
            run(w, ($urandom_range(0, 3) == 0), w2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
